multdiv_issue_ctrl: RTL and testbench
=====================================

// Module: multdiv_issue_ctrl
// PURPOSE
//  Sequences the shared multiplier/divider unit for the pipeline. Accepts one MULT/DIV op at a time from execute,
//  latches operands and destination, pulses ctrl_MULT/ctrl_DIV, waits for data_resultRDY, then presents a
//  writeback request (result, or $rstatus exception code) held until accepted. Drives stall/RAW-hazard to decode.
// PARAMETERS
//  DATA_W        32  operand/result width
//  REG_W         5   register index width
//  RSTATUS_REG   30  destination index used on exception
//  MULT_EXC      4   value written to RSTATUS_REG on mult exception
//  DIV_EXC       5   value written to RSTATUS_REG on div exception
//  RDY_MASK      2   cycles after start pulse during which md_resultRDY is ignored (stale RDY from previous op)
// PORTS
//  clock         in   1       system clock, all state on rising edge
//  reset         in   1       synchronous, active-high; returns block to IDLE
//  issue_valid   in   1       execute presents a MULT/DIV op
//  issue_is_div  in   1       1=DIV, 0=MULT
//  issue_a/b     in   DATA_W  operands
//  issue_rd      in   REG_W   destination register
//  issue_ready   out  1       op accepted this cycle when issue_valid&&issue_ready
//  dec_rs1/rs2   in   REG_W   decode source registers for hazard check
//  hazard        out  1       combinational: op in flight and nonzero dest matches dec_rs1 or dec_rs2
//  md_opA/opB    out  DATA_W  registered operands to multdiv, held stable from start until DONE
//  md_ctrl_MULT  out  1       single-cycle start pulse
//  md_ctrl_DIV   out  1       single-cycle start pulse
//  md_result     in   DATA_W  multdiv data_result
//  md_exception  in   1       multdiv data_exception
//  md_resultRDY  in   1       multdiv data_resultRDY
//  wb_valid      out  1       writeback request
//  wb_rd         out  REG_W   writeback destination
//  wb_data       out  DATA_W  writeback value
//  wb_ready      in   1       writeback port grants this cycle
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; md_ctrl_*=0, wb_valid=0, hazard=0, busy=0, md_opA/opB/wb_rd/wb_data=0, mask counter=0.
//  States: IDLE -> START (on accept) -> WAIT -> DONE -> IDLE (on wb_ready).
//  IDLE: issue_ready=1. Accept latches a,b,rd,is_div. Next cycle START.
//  START: exactly one of md_ctrl_MULT/DIV high for one cycle; mask counter loaded with RDY_MASK; -> WAIT.
//  WAIT: counter decrements to 0; md_resultRDY honoured only when counter==0. On honoured RDY latch result/exception; -> DONE.
//  DONE: wb_valid=1, outputs stable until wb_ready. No exception: wb_rd=latched rd, wb_data=md_result.
//   Exception: wb_rd=RSTATUS_REG, wb_data=DIV_EXC if div else MULT_EXC. Latched rd==0 and no exception:
//   wb_valid suppressed, DONE exits to IDLE after one cycle.
//  Back-to-back: in DONE with wb_ready=1, issue_ready=1; a simultaneous accept goes directly to START.
//  issue_ready=0 in START/WAIT; execute must hold issue_valid and stall.
//  hazard asserted in START/WAIT/DONE when latched rd!=0 and matches either source; on exception match RSTATUS_REG too.
//  Latency: accept at cycle 0 -> start pulse cycle 1 -> wb_valid one cycle after first honoured RDY.
//  Reset mid-op: IDLE next cycle, no pulse/writeback emitted; multdiv's in-flight op ignored (RDY only honoured in WAIT).
//  Divide-by-zero reported by multdiv as md_exception; block does not pre-check operands.
// STRUCTURE
//  Package multdiv_ctrl_pkg: state encoding (IDLE,START,WAIT,DONE, 2 bits), MULT_EXC/DIV_EXC/RSTATUS_REG defaults.
//  Sub-module md_hazard_check: combinational rd vs rs1/rs2 compare with zero-reg suppression.
//  Top: FSM, operand/dest registers, mask counter, result capture register.
// TESTING
//  MULT 7*6 rd=3, wb_ready=1 -> one ctrl_MULT pulse, wb_valid with rd=3 data=42, busy drops next cycle.
//  DIV 100/0 rd=5 -> one ctrl_DIV pulse, wb_rd=30 wb_data=5; MULT 0x7FFFFFFF*2 -> wb_rd=30 wb_data=4.
//  Stale RDY: hold md_resultRDY=1 across start -> not captured until RDY_MASK elapsed; correct result written.
//  wb_ready=0 for 4 cycles in DONE -> wb_valid/rd/data stable, issue_ready=0; MULT queued accepted on grant cycle.
//  In-flight rd=8, dec_rs2=8 -> hazard=1; rd=0 -> hazard=0 and no wb_valid.
//  reset asserted in WAIT -> IDLE next cycle, no wb_valid, later RDY pulse ignored, new op completes normally.

Source files
------------

// File: rtl/multdiv_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multdiv_ctrl_pkg: shared types and defaults for the multdiv issue ctrl   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } md_state_e;

  localparam int DEF_RSTATUS_REG = 30;
  localparam int DEF_MULT_EXC    = 4;
  localparam int DEF_DIV_EXC     = 5;
  localparam int DEF_RDY_MASK    = 2;

endpackage
`default_nettype wire

// File: rtl/md_hazard_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_hazard_check: destination vs decode-source compare, r0 never hazards  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module md_hazard_check #(
  parameter int REG_W = 5
) (
  input  logic             en,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             hit
);

  always_comb begin
    hit = en && (rd != '0) && ((rd == rs1) || (rd == rs2));
  end

endmodule
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multdiv_issue_ctrl: sequences one MULT/DIV op through the shared unit    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multdiv_issue_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int RSTATUS_REG = DEF_RSTATUS_REG,
  parameter int MULT_EXC    = DEF_MULT_EXC,
  parameter int DIV_EXC     = DEF_DIV_EXC,
  parameter int RDY_MASK    = DEF_RDY_MASK
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              issue_ready,
  input  logic [REG_W-1:0]  dec_rs1,
  input  logic [REG_W-1:0]  dec_rs2,
  output logic              hazard,
  output logic [DATA_W-1:0] md_opA,
  output logic [DATA_W-1:0] md_opB,
  output logic              md_ctrl_MULT,
  output logic              md_ctrl_DIV,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_resultRDY,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  output logic              busy
);

  localparam int               MASK_W      = (RDY_MASK > 0) ? $clog2(RDY_MASK + 1) : 1;
  localparam logic [REG_W-1:0] RSTATUS_IDX = REG_W'(RSTATUS_REG);

  md_state_e         state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              is_div_q, is_div_d, exc_q, exc_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              accept, wb_suppress, done_exit;
  logic              hit_rd, hit_rstatus;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rd_d         = rd_q;
    is_div_d     = is_div_q;
    exc_d        = exc_q;
    result_d     = result_q;
    mask_d       = mask_q;
    issue_ready  = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    done_exit    = 1'b0;
    // A result bound for r0 has nowhere to go, so it is dropped silently.
    wb_suppress  = (rd_q == '0) && !exc_q;

    case (state_q)
      S_IDLE: issue_ready = 1'b1;
      S_START: begin
        md_ctrl_MULT = !is_div_q;
        md_ctrl_DIV  = is_div_q;
        mask_d       = MASK_W'(RDY_MASK);
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (mask_q != '0) begin
          mask_d = mask_q - 1'b1;
        end else if (md_resultRDY) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        wb_valid    = !wb_suppress;
        wb_rd       = exc_q ? RSTATUS_IDX : rd_q;
        wb_data     = exc_q ? (is_div_q ? DATA_W'(DIV_EXC) : DATA_W'(MULT_EXC)) : result_q;
        done_exit   = wb_suppress || wb_ready;
        issue_ready = done_exit;
        if (done_exit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    accept = issue_valid && issue_ready;
    if (accept) begin
      op_a_d   = issue_a;
      op_b_d   = issue_b;
      rd_d     = issue_rd;
      is_div_d = issue_is_div;
      exc_d    = 1'b0;
      state_d  = S_START;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
      result_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      exc_q    <= exc_d;
      result_q <= result_d;
      mask_q   <= mask_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign md_opA = op_a_q;
  assign md_opB = op_b_q;

  md_hazard_check #(.REG_W(REG_W)) u_haz_rd (
    .en  (busy),
    .rd  (rd_q),
    .rs1 (dec_rs1),
    .rs2 (dec_rs2),
    .hit (hit_rd)
  );

  // Once an exception is captured the pending write targets $rstatus instead.
  md_hazard_check #(.REG_W(REG_W)) u_haz_rstatus (
    .en  ((state_q == S_DONE) && exc_q),
    .rd  (RSTATUS_IDX),
    .rs1 (dec_rs1),
    .rs2 (dec_rs2),
    .hit (hit_rstatus)
  );

  assign hazard = hit_rd || hit_rstatus;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multdiv_issue_ctrl: randomized bench with a multdiv behavioural model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multdiv_issue_ctrl;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int RSTATUS  = 30;
  localparam int MULT_EXC = 4;
  localparam int DIV_EXC  = 5;
  localparam int RDY_MASK = 2;
  localparam int NCYC     = 3000;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic              clock = 1'b0;
  logic              reset;
  logic              issue_valid, issue_is_div, issue_ready;
  logic [DATA_W-1:0] issue_a, issue_b;
  logic [REG_W-1:0]  issue_rd, dec_rs1, dec_rs2, wb_rd;
  logic              hazard, md_ctrl_MULT, md_ctrl_DIV;
  logic [DATA_W-1:0] md_opA, md_opB, md_result, wb_data;
  logic              md_exception, md_resultRDY, wb_valid, wb_ready, busy;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .hazard(hazard),
    .md_opA(md_opA), .md_opB(md_opB), .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } op_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Multdiv arithmetic: signed; overflow and divide-by-zero raise an exception.
  function automatic void md_eval(input op_t op, output logic [31:0] res, output logic exc);
    longint sa, sb, p;
    sa = longint'($signed(op.a));
    sb = longint'($signed(op.b));
    res = '0;
    exc = 1'b0;
    if (op.is_div) begin
      if (sb == 0 || (sa == MINI && sb == -1)) exc = 1'b1;
      else res = 32'(sa / sb);
    end else begin
      p   = sa * sb;
      exc = (p > MAXI) || (p < MINI);
      res = 32'(p);
    end
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.is_div = 1'($urandom_range(0, 1));
    o.a      = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
    case ($urandom_range(0, 5))
      0:       o.b = '0;
      1:       o.b = $urandom;
      default: o.b = 32'($urandom_range(1, 40));
    endcase
    o.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    return o;
  endfunction

  op_t         directed[$];
  op_t         p_op, m_op;
  logic        p_valid;
  logic        m_busy, m_done, m_exc, m_cleared;
  logic [31:0] m_res;
  int          m_age, ready_age;

  logic exp_sup, exp_wbv, exp_exit, exp_ready, exp_haz, do_reset;
  logic [4:0]  exp_wrd;
  logic [31:0] exp_wdata;

  initial begin
    directed.push_back('{1'b0, 32'd7,          32'd6,   5'd3});
    directed.push_back('{1'b1, 32'd100,        32'd0,   5'd5});
    directed.push_back('{1'b0, 32'h7FFF_FFFF,  32'd2,   5'd9});
    directed.push_back('{1'b0, 32'd3,          32'd4,   5'd0});
    directed.push_back('{1'b1, 32'd50,         32'd7,   5'd8});

    reset = 1'b1; issue_valid = 1'b0; issue_is_div = 1'b0; issue_a = '0; issue_b = '0;
    issue_rd = '0; dec_rs1 = '0; dec_rs2 = '0; md_result = '0; md_exception = 1'b0;
    md_resultRDY = 1'b0; wb_ready = 1'b0;
    p_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_exc = 1'b0; m_cleared = 1'b1;
    m_res = '0; m_age = 0; ready_age = 0; m_op = '{1'b0, 32'd0, 32'd0, 5'd0}; p_op = m_op;

    repeat (2) @(negedge clock);
    #1;
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_ready",    32'(issue_ready),  32'd1);
    check("rst_wbv",      32'(wb_valid),     32'd0);
    check("rst_mult",     32'(md_ctrl_MULT), 32'd0);
    check("rst_div",      32'(md_ctrl_DIV),  32'd0);
    check("rst_hazard",   32'(hazard),       32'd0);
    check("rst_opA",      md_opA,            32'd0);
    check("rst_opB",      md_opB,            32'd0);
    check("rst_wb_rd",    32'(wb_rd),        32'd0);
    check("rst_wb_data",  wb_data,           32'd0);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      do_reset = (cyc > 40) && m_busy && !m_done && (m_age >= 2) && ($urandom_range(0, 14) == 0);
      reset = do_reset;

      if (!p_valid && $urandom_range(0, 2) != 0) begin
        p_valid = 1'b1;
        p_op = (directed.size() > 0) ? directed.pop_front() : rand_op();
      end
      issue_valid  = p_valid;
      issue_is_div = p_op.is_div;
      issue_a      = p_op.a;
      issue_b      = p_op.b;
      issue_rd     = p_op.rd;
      wb_ready     = ($urandom_range(0, 9) < 6);
      dec_rs1      = ($urandom_range(0, 5) == 0) ? 5'd30 : 5'($urandom);
      dec_rs2      = ($urandom_range(0, 1) == 0) ? m_op.rd : 5'($urandom);

      // Multdiv model: noisy/stale RDY outside the honoured window, real result later.
      if (m_busy && !m_done && m_age >= 2 + RDY_MASK) begin
        md_resultRDY = (m_age >= ready_age);
        md_result    = (m_age >= ready_age) ? m_res : $urandom;
        md_exception = (m_age >= ready_age) ? m_exc : 1'($urandom);
      end else begin
        md_resultRDY = 1'($urandom);
        md_result    = $urandom;
        md_exception = 1'($urandom);
      end
      #1;

      exp_sup   = m_busy && m_done && (m_op.rd == 5'd0) && !m_exc;
      exp_wbv   = m_busy && m_done && !exp_sup;
      exp_exit  = m_busy && m_done && (exp_sup || wb_ready);
      exp_ready = !m_busy || exp_exit;
      exp_haz   = m_busy && (((m_op.rd != 0) && (m_op.rd == dec_rs1 || m_op.rd == dec_rs2)) ||
                  (m_done && m_exc && (dec_rs1 == 5'(RSTATUS) || dec_rs2 == 5'(RSTATUS))));
      exp_wrd   = m_exc ? 5'(RSTATUS) : m_op.rd;
      exp_wdata = m_exc ? (m_op.is_div ? 32'(DIV_EXC) : 32'(MULT_EXC)) : m_res;

      check("busy",        32'(busy),         32'(m_busy));
      check("issue_ready", 32'(issue_ready),  32'(exp_ready));
      check("ctrl_MULT",   32'(md_ctrl_MULT), 32'(m_busy && m_age == 1 && !m_op.is_div));
      check("ctrl_DIV",    32'(md_ctrl_DIV),  32'(m_busy && m_age == 1 && m_op.is_div));
      check("wb_valid",    32'(wb_valid),     32'(exp_wbv));
      check("hazard",      32'(hazard),       32'(exp_haz));
      if (m_busy) begin
        check("md_opA", md_opA, m_op.a);
        check("md_opB", md_opB, m_op.b);
      end else if (m_cleared) begin
        check("clr_opA", md_opA, 32'd0);
        check("clr_opB", md_opB, 32'd0);
      end
      if (exp_wbv) begin
        check("wb_rd",   32'(wb_rd), 32'(exp_wrd));
        check("wb_data", wb_data,    exp_wdata);
      end

      if (do_reset) begin
        m_busy = 1'b0; m_done = 1'b0; m_cleared = 1'b1;
      end else begin
        if (m_busy) begin
          if (exp_exit) m_busy = 1'b0;
          else if (!m_done && m_age >= 2 + RDY_MASK && md_resultRDY) m_done = 1'b1;
          m_age++;
        end
        if (issue_valid && exp_ready) begin
          m_op = p_op;
          md_eval(p_op, m_res, m_exc);
          m_busy = 1'b1; m_done = 1'b0; m_age = 1; m_cleared = 1'b0;
          ready_age = 2 + RDY_MASK + int'($urandom_range(0, 3));
          p_valid = 1'b0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
